// File: rtl/stage_wrapper_pkg.sv
// Shared parameters and window-state encoding for the RS decoder stage wrapper.
// The wrapper top and the window counter both import this package.
package stage_wrapper_pkg;

    localparam int WIDTH    = 8;
    localparam int LEN_WORD = 15;
    localparam int CNT_W    = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } win_state_e;

    // True when a CNT_W-bit counter can hold every index 0..len-1.
    function automatic bit cnt_fits(input int len, input int cnt_w);
        return (len >= 1) && ((64'd1 << cnt_w) >= 64'(len));
    endfunction

endpackage

// File: rtl/stage_window_cnt.sv
// Window FSM: opens a LEN_WORD-cycle window on each accepted first strobe and
// decodes the final window cycle as a combinational last pulse.
module stage_window_cnt
    import stage_wrapper_pkg::*;
#(
    parameter int LEN_WORD = stage_wrapper_pkg::LEN_WORD,
    parameter int CNT_W    = stage_wrapper_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_ena,
    input  logic first,
    output logic windows,
    output logic last
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN_WORD - 1);

    win_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             windows_q, windows_d;
    logic             at_end;

    assign at_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        windows_d = windows_q;
        if (clk_ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (first) begin
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        windows_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    // A strobe restarts the window whether or not it lands on
                    // the final cycle; on the final cycle this gives a gapless
                    // back-to-back packet.
                    if (first) begin
                        cnt_d     = '0;
                        windows_d = 1'b1;
                    end else if (at_end) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        windows_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    windows_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            windows_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            windows_q <= windows_d;
        end
    end

    assign windows = windows_q;
    assign last    = windows_q & at_end;

endmodule

// File: rtl/stage_wrapper.sv
// One pipeline stage of the RS decoder syndrome-bus datapath: registers the
// symbol bus, captures it at packet start and tracks the processing window.
module stage_wrapper
    import stage_wrapper_pkg::*;
#(
    parameter int WIDTH    = stage_wrapper_pkg::WIDTH,
    parameter int LEN_WORD = stage_wrapper_pkg::LEN_WORD,
    parameter int CNT_W    = stage_wrapper_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_ena,
    input  logic             first,
    input  logic [WIDTH-1:0] pin,
    output logic             windows,
    output logic             last,
    output logic [WIDTH-1:0] pin_latch,
    output logic [WIDTH-1:0] pout
);

    if (!cnt_fits(LEN_WORD, CNT_W)) begin : g_bad_cnt_w
        $error("stage_wrapper: CNT_W too narrow for LEN_WORD");
    end

    logic [WIDTH-1:0] pout_q, pout_d;
    logic [WIDTH-1:0] pin_latch_q, pin_latch_d;

    always_comb begin
        pout_d      = pout_q;
        pin_latch_d = pin_latch_q;
        if (clk_ena) begin
            pout_d = pin;
            if (first) pin_latch_d = pin;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pout_q      <= '0;
            pin_latch_q <= '0;
        end else begin
            pout_q      <= pout_d;
            pin_latch_q <= pin_latch_d;
        end
    end

    assign pout      = pout_q;
    assign pin_latch = pin_latch_q;

    stage_window_cnt #(
        .LEN_WORD (LEN_WORD),
        .CNT_W    (CNT_W)
    ) u_window_cnt (
        .clk     (clk),
        .rst     (rst),
        .clk_ena (clk_ena),
        .first   (first),
        .windows (windows),
        .last    (last)
    );

endmodule

// File: tb/tb_stage_wrapper.sv
// Directed plus randomized bench for stage_wrapper against a window-position
// reference model.
module tb_stage_wrapper;

    localparam int LEN = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_ena = 1'b1;
    logic       first = 1'b0;
    logic [7:0] pin = 8'h00;
    logic       windows, last;
    logic [7:0] pin_latch, pout;

    int checks = 0;
    int failures = 0;

    // Reference model: whether a window is open and which window cycle (1..LEN)
    // is currently being presented.
    bit       m_act = 1'b0;
    int       m_pos = 0;
    logic [7:0] m_latch = 8'h00;
    logic [7:0] m_pout = 8'h00;

    stage_wrapper dut (
        .clk       (clk),
        .rst       (rst),
        .clk_ena   (clk_ena),
        .first     (first),
        .pin       (pin),
        .windows   (windows),
        .last      (last),
        .pin_latch (pin_latch),
        .pout      (pout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_last();
        return m_act && (m_pos == LEN);
    endfunction

    task automatic model_reset();
        m_act = 1'b0; m_pos = 0; m_latch = 8'h00; m_pout = 8'h00;
    endtask

    task automatic model_edge();
        if (!rst) model_reset();
        else if (clk_ena) begin
            m_pout = pin;
            if (first) begin
                m_latch = pin; m_act = 1'b1; m_pos = 1;
            end else if (m_act) begin
                if (m_pos == LEN) begin m_act = 1'b0; m_pos = 0; end
                else m_pos++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".windows"}, 32'(windows), 32'(m_act));
        chk({tag, ".last"}, 32'(last), 32'(exp_last()));
        chk({tag, ".pout"}, 32'(pout), 32'(m_pout));
        chk({tag, ".pin_latch"}, 32'(pin_latch), 32'(m_latch));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1 model_reset();
        chk({tag, ".windows"}, 32'(windows), 32'd0);
        chk({tag, ".last"}, 32'(last), 32'd0);
        chk({tag, ".pout"}, 32'(pout), 32'd0);
        chk({tag, ".pin_latch"}, 32'(pin_latch), 32'd0);
    endtask

    initial begin
        int win_cnt, last_cnt, last_at, gaps, clocks;

        // Reset held with a live bus value
        pin = 8'hA5;
        #1 check_all("rst_hold");
        chk("rst_pout_zero", 32'(pout), 32'd0);
        step("rst_hold_e1");
        step("rst_hold_e2");
        rst = 1'b1;
        step("rst_release");
        chk("rst_release_pout", 32'(pout), 32'hA5);
        chk("rst_release_win", 32'(windows), 32'd0);
        step("idle");

        // Single packet
        pin = 8'h3C; first = 1'b1;
        step("single_first");
        chk("single_latch", 32'(pin_latch), 32'h3C);
        first = 1'b0;
        win_cnt = 1; last_cnt = 0; last_at = 0;
        for (int i = 2; i <= 20; i++) begin
            pin = 8'($urandom);
            step("single");
            if (windows) win_cnt++;
            if (last) begin last_cnt++; last_at = i; end
        end
        chk("single_win_len", 32'(win_cnt), 32'd15);
        chk("single_last_cnt", 32'(last_cnt), 32'd1);
        chk("single_last_at", 32'(last_at), 32'd15);

        // Back-to-back packets, new strobe on each last cycle
        gaps = 0; last_cnt = 0;
        first = 1'b1; pin = 8'h11;
        for (int p = 0; p < 4; p++) begin
            step("b2b_first");
            chk("b2b_latch", 32'(pin_latch), 32'(8'h11 * (p + 1)));
            first = 1'b0;
            for (int i = 0; i < 14; i++) begin
                pin = 8'($urandom);
                step("b2b");
                if (!windows) gaps++;
                if (last) last_cnt++;
            end
            first = (p < 3); pin = 8'(8'h11 * (p + 2));
        end
        chk("b2b_no_gap", 32'(gaps), 32'd0);
        chk("b2b_last_cnt", 32'(last_cnt), 32'd4);
        first = 1'b0;
        step("b2b_tail");
        step("b2b_idle");

        // Enable gating mid-window; a strobe while disabled is ignored
        pin = 8'h5A; first = 1'b1;
        step("ena_first");
        first = 1'b0; clocks = 1;
        for (int i = 0; i < 4; i++) begin step("ena_run"); clocks++; end
        clk_ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            first = (i == 1); pin = 8'($urandom);
            step("ena_frozen"); clocks++;
        end
        first = 1'b0; clk_ena = 1'b1;
        while (windows && clocks < 40) begin step("ena_run2"); clocks++; end
        chk("ena_window_clocks", 32'(clocks), 32'd19);
        chk("ena_latch_kept", 32'(pin_latch), 32'h5A);

        // Restart at window cycle 5
        first = 1'b1; pin = 8'h71;
        step("rs_first1");
        first = 1'b0;
        for (int i = 0; i < 4; i++) step("rs_run");
        first = 1'b1; pin = 8'h72;
        step("rs_first2");
        chk("rs_latch_reload", 32'(pin_latch), 32'h72);
        first = 1'b0; last_at = 0; last_cnt = 0;
        for (int i = 2; i <= 16; i++) begin
            step("rs_run2");
            if (last) begin last_cnt++; last_at = i; end
        end
        chk("rs_last_cnt", 32'(last_cnt), 32'd1);
        chk("rs_last_at", 32'(last_at), 32'd15);
        step("rs_idle");

        // Async reset at window cycle 7
        first = 1'b1; pin = 8'h99;
        step("mr_first");
        first = 1'b0;
        for (int i = 0; i < 6; i++) step("mr_run");
        chk("mr_pre_win", 32'(windows), 32'd1);
        async_reset("mr_async");
        step("mr_held");
        rst = 1'b1;
        step("mr_release");

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            clk_ena = ($urandom_range(0, 7) != 0);
            pin     = 8'($urandom);
            if (exp_last()) first = ($urandom_range(0, 1) == 1);
            else            first = ($urandom_range(0, 24) == 0);
            rst = 1'b1;
            step("rand");
            if ($urandom_range(0, 149) == 0) async_reset("rand_async");
        end
        rst = 1'b1; first = 1'b0; clk_ena = 1'b1;
        step("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
